// File: rtl/time_pkg.sv
// time_pkg: shared widths, limits and the time record used by the time source
// and the overlay renderer.
//   HOUR_W/MIN_W/SEC_W : field widths
//   HOUR_MAX/MIN_MAX/SEC_MAX : last value before a field wraps to 0
//   time_t : packed {hour, min, sec, blink}
//   inc_wrap : increment a minute/second-sized field, wrapping after max_v
package time_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic              blink;
  } time_t;

  function automatic logic [MIN_W-1:0] inc_wrap(input logic [MIN_W-1:0] v,
                                                input logic [MIN_W-1:0] max_v);
    return (v == max_v) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/time_if.sv
// time_if: bundle carrying the wall-clock fields to the overlay renderer.
//   modport out : driven by time_keeper
//   modport in  : sampled by consumers (through their own synchronisers)
interface time_if;
  logic [time_pkg::HOUR_W-1:0] hour;
  logic [time_pkg::MIN_W-1:0]  min;
  logic [time_pkg::SEC_W-1:0]  sec;
  logic                        blink;

  modport out (output hour, min, sec, blink);
  modport in  (input  hour, min, sec, blink);
endinterface

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: synchronise and debounce one raw push-button, emit a single
// cycle pulse on each accepted press.
//   clk_50_i : system clock
//   rst_i    : asynchronous active-high reset
//   btn_i    : raw asynchronous button, active-high
//   press_o  : 1-cycle pulse on a rising edge of the debounced level
module btn_sync_edge #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_50_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_d_q;
  logic             press_q;

  // cnt_q counts consecutive synchronised samples that disagree with the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      level_d_q <= level_q;
      press_q   <= level_q & ~level_d_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_keeper.sv
// time_keeper: wall-clock source (hour/min/sec plus colon blink) with two
// set buttons.
//   CLK_FREQ     : input clock frequency in Hz (divider wraps at CLK_FREQ-1)
//   DEBOUNCE_CYC : stable cycles needed before a button level is accepted
//   clk_50_i     : system clock
//   rst_i        : asynchronous active-high reset
//   btn_hour_i   : raw hour-set button
//   btn_min_i    : raw minute-set button
//   time_info    : registered hour, min, sec, blink
module time_keeper
  import time_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_50_i,
  input  logic rst_i,
  input  logic btn_hour_i,
  input  logic btn_min_i,
  time_if.out  time_info
);

  localparam int unsigned DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_FREQ / 2);

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_n;
  time_t             time_q;
  time_t             time_n;
  logic              set_hour;
  logic              set_min;
  logic              tick;
  logic              min_carry;
  logic [HOUR_W:0]   hour_sum;

  btn_sync_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_hour_btn (
    .clk_50_i (clk_50_i),
    .rst_i    (rst_i),
    .btn_i    (btn_hour_i),
    .press_o  (set_hour)
  );

  btn_sync_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_min_btn (
    .clk_50_i (clk_50_i),
    .rst_i    (rst_i),
    .btn_i    (btn_min_i),
    .press_o  (set_min)
  );

  always_comb begin
    tick      = (div_q == DIV_LAST);
    div_n     = tick ? '0 : div_q + 1'b1;
    time_n    = time_q;
    min_carry = 1'b0;

    // A minute press restarts the second and swallows any coincident tick.
    if (set_min) begin
      div_n      = '0;
      time_n.sec = '0;
      time_n.min = inc_wrap(time_q.min, MIN_W'(MIN_MAX));
    end else if (tick) begin
      time_n.sec = inc_wrap(time_q.sec, SEC_W'(SEC_MAX));
      if (time_q.sec == SEC_W'(SEC_MAX)) begin
        time_n.min = inc_wrap(time_q.min, MIN_W'(MIN_MAX));
        min_carry  = (time_q.min == MIN_W'(MIN_MAX));
      end
    end

    // Hour press and minute carry can land together, so the hour may
    // advance by two (23 -> 1).
    hour_sum = {1'b0, time_q.hour} + {{HOUR_W{1'b0}}, set_hour}
             + {{HOUR_W{1'b0}}, min_carry};
    if (hour_sum > (HOUR_W+1)'(HOUR_MAX)) begin
      time_n.hour = HOUR_W'(hour_sum - (HOUR_W+1)'(HOUR_MAX + 1));
    end else begin
      time_n.hour = hour_sum[HOUR_W-1:0];
    end

    time_n.blink = (div_n < DIV_HALF);
  end

  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      time_q <= '{hour: '0, min: '0, sec: '0, blink: 1'b1};
    end else begin
      div_q  <= div_n;
      time_q <= time_n;
    end
  end

  assign time_info.hour  = time_q.hour;
  assign time_info.min   = time_q.min;
  assign time_info.sec   = time_q.sec;
  assign time_info.blink = time_q.blink;

endmodule
